demux_sched_1x2: RTL
====================

DEMUX_SCHED_1X2 -- requirements
Module: demux_sched_1x2

Interface
REQ-001 Parameter DW, default 8, data width in bits.
REQ-002 Parameter CW, default 8, packet-counter width in bits.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 mode  input  1  0 = in_sel-directed routing, 1 = round-robin routing.
REQ-006 in_valid  input  1  input beat valid.
REQ-007 in_ready  output  1  block accepts the input beat this cycle.
REQ-008 in_data  input  DW  input beat payload.
REQ-009 in_sel  input  1  requested destination; used in mode 0 on the first beat only.
REQ-010 in_last  input  1  final beat of the packet.
REQ-011 outK_valid, outK_ready, outK_data[DW], outK_last  (K=0,1)  output/input/output/output  per-destination stream.
REQ-012 pkt_cnt0, pkt_cnt1  output  CW  packets completed per destination.
REQ-013 busy  output  1  packet in progress or beat held.

Function
REQ-014 Transfer occurs on a port when its valid and ready are both 1 on a rising edge.
REQ-015 One holding register (hold_valid, hold_data, hold_last, hold_dest) sits between the input and the outputs; input-to-output latency is exactly 1 cycle.
REQ-016 outK_valid = hold_valid & (hold_dest==K); outK_data/outK_last = hold values when outK_valid, else all-zero.
REQ-017 in_ready = !hold_valid | out[hold_dest]_ready (combinational pass-through); it never depends on in_valid.
REQ-018 FSM states: IDLE, LOCK0, LOCK1.
REQ-019 In IDLE, the destination of an accepted beat is in_sel (mode 0) or rr_ptr (mode 1); mode is sampled only at this point.
REQ-020 IDLE -> LOCKd when the accepted first beat has in_last=0; it stays IDLE when in_last=1 (single-beat packet).
REQ-021 In LOCKd, every accepted beat routes to d, ignoring in_sel and mode; LOCKd -> IDLE when a beat with in_last=1 is accepted.
REQ-022 rr_ptr toggles when the last beat of a packet is accepted while that packet started in mode 1; it does not change otherwise.
REQ-023 pkt_cntK increments by 1 when outK_valid & outK_ready & outK_last, wrapping from 2^CW-1 to 0.
REQ-024 busy = (state!=IDLE) | hold_valid.
REQ-025 Simultaneous drain and accept: the holding register reloads in the same cycle with no bubble.
REQ-026 The non-selected output's ready is ignored; backpressure on one destination stalls the whole input.

Reset
REQ-027 On rst assertion: state=IDLE, hold_valid=0, hold_data=0, hold_last=0, hold_dest=0, rr_ptr=0, pkt_cnt0=pkt_cnt1=0; therefore out0_valid=out1_valid=0, busy=0, in_ready=1.
REQ-028 Reset mid-packet discards the held beat and the lock; the first beat after release is treated as a packet start.

Structure
REQ-029 Package demux_sched_pkg holds the state enum (IDLE, LOCK0, LOCK1), DEST0/DEST1 constants, and DW/CW defaults.
REQ-030 The per-destination wrapping counter is one sub-module, pkt_counter, instantiated twice.

Verification
REQ-031 After reset, with mode=0 and outK_ready=1: single beat in_data=0xA5, in_sel=1, in_last=1 -> next cycle out1_valid=1, out1_data=0xA5, out0_data=0, pkt_cnt1=1 one cycle later.
REQ-032 Mode=0, 3-beat packet 0x11, 0x22, 0x33 with in_sel=0, 1, 1 -> all three beats on out0 on consecutive cycles, pkt_cnt0=1, pkt_cnt1=0.
REQ-033 Mode=1, four single-beat packets 0x01..0x04 -> destinations 0, 1, 0, 1; pkt_cnt0=2, pkt_cnt1=2.
REQ-034 Beat held for out0 with out0_ready=0 for 3 cycles and out1_ready=1 -> in_ready=0 and out0_data stable for 3 cycles; the beat drains and the next beat loads on the cycle out0_ready rises.
REQ-035 rst asserted during beat 2 of a 4-beat LOCK1 packet -> outputs zero immediately, state IDLE; a subsequent in_sel=0 beat routes to out0.
REQ-036 CW=8: 256 single-beat packets to out0 -> pkt_cnt0 wraps to 0.

Source files
------------

// File: rtl/demux_sched_pkg.sv
// Shared types and constants for the 1-to-2 packet demultiplexer.
package demux_sched_pkg;

  localparam int unsigned DW_DEF = 8;
  localparam int unsigned CW_DEF = 8;

  localparam logic DEST0 = 1'b0;
  localparam logic DEST1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    LOCK0,
    LOCK1
  } state_e;

endpackage

// File: rtl/pkt_counter.sv
// Wrapping per-destination packet counter.
module pkt_counter #(
  parameter int unsigned CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  output logic [CW-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/demux_sched_1x2.sv
// 1-to-2 packet demux: sel-directed or round-robin routing, packets locked to one
// destination, single holding register between input and outputs.
module demux_sched_1x2
  import demux_sched_pkg::*;
#(
  parameter int unsigned DW = DW_DEF,
  parameter int unsigned CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mode,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic          in_sel,
  input  logic          in_last,
  output logic          out0_valid,
  input  logic          out0_ready,
  output logic [DW-1:0] out0_data,
  output logic          out0_last,
  output logic          out1_valid,
  input  logic          out1_ready,
  output logic [DW-1:0] out1_data,
  output logic          out1_last,
  output logic [CW-1:0] pkt_cnt0,
  output logic [CW-1:0] pkt_cnt1,
  output logic          busy
);

  state_e        state;
  logic          hold_valid;
  logic [DW-1:0] hold_data;
  logic          hold_last;
  logic          hold_dest;
  logic          rr_ptr;
  logic          pkt_rr;

  logic sel_ready;
  logic accept;
  logic in_dest;
  logic pkt_is_rr;

  // Only the ready of the destination currently held matters.
  assign sel_ready = (hold_dest == DEST1) ? out1_ready : out0_ready;
  assign in_ready  = !hold_valid | sel_ready;
  assign accept    = in_valid & in_ready;

  // Routing decision; mode and in_sel only count on a packet's first beat.
  always_comb begin
    in_dest   = DEST0;
    pkt_is_rr = 1'b0;
    unique case (state)
      IDLE: begin
        in_dest   = mode ? rr_ptr : in_sel;
        pkt_is_rr = mode;
      end
      LOCK0: begin
        in_dest   = DEST0;
        pkt_is_rr = pkt_rr;
      end
      LOCK1: begin
        in_dest   = DEST1;
        pkt_is_rr = pkt_rr;
      end
      default: begin
        in_dest   = DEST0;
        pkt_is_rr = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      hold_valid <= 1'b0;
      hold_data  <= '0;
      hold_last  <= 1'b0;
      hold_dest  <= DEST0;
      rr_ptr     <= 1'b0;
      pkt_rr     <= 1'b0;
    end else begin
      if (accept) begin
        hold_valid <= 1'b1;
        hold_data  <= in_data;
        hold_last  <= in_last;
        hold_dest  <= in_dest;
      end else if (hold_valid && sel_ready) begin
        hold_valid <= 1'b0;
      end

      if (accept) begin
        if (state == IDLE) begin
          pkt_rr <= mode;
        end
        if (in_last) begin
          state <= IDLE;
          if (pkt_is_rr) begin
            rr_ptr <= ~rr_ptr;
          end
        end else begin
          state <= (in_dest == DEST1) ? LOCK1 : LOCK0;
        end
      end
    end
  end

  assign out0_valid = hold_valid & (hold_dest == DEST0);
  assign out1_valid = hold_valid & (hold_dest == DEST1);
  assign out0_data  = out0_valid ? hold_data : '0;
  assign out1_data  = out1_valid ? hold_data : '0;
  assign out0_last  = out0_valid & hold_last;
  assign out1_last  = out1_valid & hold_last;

  assign busy = (state != IDLE) | hold_valid;

  pkt_counter #(
    .CW(CW)
  ) u_cnt0 (
    .clk  (clk),
    .rst  (rst),
    .inc  (out0_valid & out0_ready & out0_last),
    .count(pkt_cnt0)
  );

  pkt_counter #(
    .CW(CW)
  ) u_cnt1 (
    .clk  (clk),
    .rst  (rst),
    .inc  (out1_valid & out1_ready & out1_last),
    .count(pkt_cnt1)
  );

endmodule
